// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM with memory-wait timeout
// and illegal-opcode detection; outputs are Moore, qualified by mem_ready where needed.
module mips_multicycle_control #(
   parameter int MAX_WAIT = 15
) (
   input  logic       clk_CPU,
   input  logic       rst_CPU_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       error,
   output logic [1:0] err_code,
   output logic [3:0] state
);
   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [1:0] EC_ILL   = 2'b01;
   localparam logic [1:0] EC_TMO   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC     = 4'd6,
      S_RWB      = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDIEX   = 4'd10,
      S_ADDIWB   = 4'd11,
      S_ERROR    = 4'd12
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [WW-1:0]   r_wait;
   logic [1:0]      r_err_code;
   logic [1:0]      w_err_code;
   logic            w_waiting;
   logic            w_timeout;

   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
   // A ready handshake in the limit cycle still wins over the timeout.
   assign w_timeout = w_waiting && !mem_ready && (r_wait == WW'(MAX_WAIT));

   always_ff @(posedge clk_CPU) begin
      if (!rst_CPU_n) begin
         r_state    <= S_FETCH;
         r_wait     <= '0;
         r_err_code <= 2'b00;
      end else begin
         r_state    <= w_next;
         r_err_code <= w_err_code;
         r_wait     <= (w_next != r_state) ? '0 : (w_waiting && !mem_ready) ? r_wait + 1'b1 : r_wait;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_err_code = r_err_code;
      case (r_state)
         S_FETCH:    if (mem_ready) w_next = S_DECODE;
         S_DECODE:
            case (opcode)
               OP_RTYPE:     w_next = S_EXEC;
               OP_LW, OP_SW: w_next = S_MEMADDR;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               OP_ADDI:      w_next = S_ADDIEX;
               default: begin
                  w_next     = S_ERROR;
                  w_err_code = EC_ILL;
               end
            endcase
         S_MEMADDR:  w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
         S_EXEC:     w_next = S_RWB;
         S_RWB:      w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_JUMP:     w_next = S_FETCH;
         S_ADDIEX:   w_next = S_ADDIWB;
         S_ADDIWB:   w_next = S_FETCH;
         S_ERROR:    w_next = S_ERROR;
         default: begin
            w_next     = S_ERROR;
            w_err_code = EC_ILL;
         end
      endcase
      if (w_timeout) begin
         w_next     = S_ERROR;
         w_err_code = EC_TMO;
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      instr_done  = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE:   ALUSrcB = 2'b11;
         S_MEMADDR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMREAD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_RWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign error    = (r_state == S_ERROR);
   assign err_code = r_err_code;
   assign state    = r_state;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: table-driven per-cycle checks of state and control
// outputs through a scoreboard queue, plus timeout boundary sequences.
module tb_mips_multicycle_control;
   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_R = 6'h00, OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J = 6'h02, OP_ADDI = 6'h08, OP_BAD = 6'h3F;
   // ctrl = {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource}
   localparam logic [15:0] C_F0 = 16'h1010, C_F1 = 16'h9410, C_DEC = 16'h0030, C_MA = 16'h0060;
   localparam logic [15:0] C_MR = 16'h3000, C_WB = 16'h0300, C_MW = 16'h2800, C_EX = 16'h0048;
   localparam logic [15:0] C_RWB = 16'h0180, C_BR = 16'h4045, C_J = 16'h8002, C_AI = 16'h0060;
   localparam logic [15:0] C_AW = 16'h0100, C_Z = 16'h0000;

   typedef struct {
      string       tag;
      logic [5:0]  op;
      logic        mr;
      logic        rn;
      logic [3:0]  st;
      logic [15:0] ctrl;
      logic        done;
      logic        err;
      logic [1:0]  ec;
   } vec_t;

   logic clk_CPU = 1'b0;
   logic rst_CPU_n, mem_ready;
   logic [5:0] opcode;
   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource, err_code;
   logic instr_done, error;
   logic [3:0] state;
   logic [15:0] ctrl;

   vec_t vec[$];
   vec_t sb[$];
   int errors = 0;
   int checks = 0;

   mips_multicycle_control #(.MAX_WAIT(15)) dut (
      .clk_CPU(clk_CPU), .rst_CPU_n(rst_CPU_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .instr_done(instr_done), .error(error), .err_code(err_code), .state(state)
   );

   assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                  RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource};

   always #5 clk_CPU = ~clk_CPU;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   function automatic vec_t mk(string tag, logic [5:0] op, logic mr, logic rn, logic [3:0] st,
                               logic [15:0] c, logic d, logic er, logic [1:0] ec);
      vec_t v;
      v.tag = tag; v.op = op; v.mr = mr; v.rn = rn; v.st = st;
      v.ctrl = c; v.done = d; v.err = er; v.ec = ec;
      return v;
   endfunction

   function automatic void add(string tag, logic [5:0] op, logic mr, logic rn, logic [3:0] st,
                               logic [15:0] c, logic d, logic er, logic [1:0] ec);
      vec.push_back(mk(tag, op, mr, rn, st, c, d, er, ec));
   endfunction

   task automatic chk(string tag, string f, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", tag, f, act, exp);
      end
   endtask

   task automatic cyc(input vec_t v);
      vec_t e;
      @(posedge clk_CPU);
      #1;
      opcode    = v.op;
      mem_ready = v.mr;
      rst_CPU_n = v.rn;
      sb.push_back(v);
      @(negedge clk_CPU);
      e = sb.pop_front();
      chk(e.tag, "state", {12'd0, state}, {12'd0, e.st});
      chk(e.tag, "ctrl", ctrl, e.ctrl);
      chk(e.tag, "instr_done", {15'd0, instr_done}, {15'd0, e.done});
      chk(e.tag, "error", {15'd0, error}, {15'd0, e.err});
      chk(e.tag, "err_code", {14'd0, err_code}, {14'd0, e.ec});
   endtask

   task automatic rst_pulse();
      @(posedge clk_CPU);
      #1;
      rst_CPU_n = 1'b0;
      mem_ready = 1'b0;
      opcode    = OP_R;
   endtask

   initial begin
      rst_CPU_n = 1'b0;
      opcode    = OP_R;
      mem_ready = 1'b0;
      add("reset", OP_R, 0, 1, 0, C_F0, 0, 0, 2'b00);
      // lw with no wait states: 0,1,2,3,4
      add("lw_f", OP_LW, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("lw_d", OP_LW, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("lw_ma", OP_LW, 1, 1, 2, C_MA, 0, 0, 2'b00);
      add("lw_mr", OP_LW, 1, 1, 3, C_MR, 0, 0, 2'b00);
      add("lw_wb", OP_LW, 1, 1, 4, C_WB, 1, 0, 2'b00);
      // sw with three wait cycles in MEMWRITE
      add("sw_f", OP_SW, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("sw_d", OP_SW, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("sw_ma", OP_SW, 1, 1, 2, C_MA, 0, 0, 2'b00);
      for (int i = 0; i < 3; i++) add("sw_wait", OP_SW, 0, 1, 5, C_MW, 0, 0, 2'b00);
      add("sw_done", OP_SW, 1, 1, 5, C_MW, 1, 0, 2'b00);
      // R-type, beq, j, addi back to back
      add("r_f", OP_R, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("r_d", OP_R, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("r_ex", OP_R, 1, 1, 6, C_EX, 0, 0, 2'b00);
      add("r_wb", OP_R, 1, 1, 7, C_RWB, 1, 0, 2'b00);
      add("beq_f", OP_BEQ, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("beq_d", OP_BEQ, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("beq_br", OP_BEQ, 1, 1, 8, C_BR, 1, 0, 2'b00);
      add("j_f", OP_J, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("j_d", OP_J, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("j_j", OP_J, 1, 1, 9, C_J, 1, 0, 2'b00);
      add("addi_f", OP_ADDI, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("addi_d", OP_ADDI, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("addi_ex", OP_ADDI, 1, 1, 10, C_AI, 0, 0, 2'b00);
      add("addi_wb", OP_ADDI, 1, 1, 11, C_AW, 1, 0, 2'b00);
      // illegal opcode, sticky for 20 cycles, cleared by reset
      add("bad_f", OP_BAD, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("bad_d", OP_BAD, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      for (int i = 0; i < 20; i++) add("bad_hold", OP_BAD, i[0], 1, 12, C_Z, 0, 1, 2'b01);
      add("bad_rst", OP_R, 1, 0, 12, C_Z, 0, 1, 2'b01);
      add("bad_clr", OP_R, 0, 1, 0, C_F0, 0, 0, 2'b00);
      // reset while in MEMREAD: no RegWrite afterwards
      add("rmr_f", OP_LW, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("rmr_d", OP_LW, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("rmr_ma", OP_LW, 1, 1, 2, C_MA, 0, 0, 2'b00);
      add("rmr_mr", OP_LW, 0, 0, 3, C_MR, 0, 0, 2'b00);
      add("rmr_after", OP_LW, 0, 1, 0, C_F0, 0, 0, 2'b00);
      // reset while in MEMWRITE: no write strobe or instr_done afterwards
      add("rmw_f", OP_SW, 1, 1, 0, C_F1, 0, 0, 2'b00);
      add("rmw_d", OP_SW, 1, 1, 1, C_DEC, 0, 0, 2'b00);
      add("rmw_ma", OP_SW, 1, 1, 2, C_MA, 0, 0, 2'b00);
      add("rmw_mw", OP_SW, 1, 0, 5, C_MW, 1, 0, 2'b00);
      add("rmw_after", OP_SW, 1, 1, 0, C_F1, 0, 0, 2'b00);
      repeat (2) @(posedge clk_CPU);
      for (int i = 0; i < vec.size(); i++) cyc(vec[i]);

      // FETCH timeout: 16 cycles without ready
      rst_pulse();
      for (int i = 0; i < 16; i++) cyc(mk("tmo_fetch", OP_R, 0, 1, 0, C_F0, 0, 0, 2'b00));
      cyc(mk("tmo_err", OP_R, 1, 1, 12, C_Z, 0, 1, 2'b10));
      cyc(mk("tmo_hold", OP_R, 1, 1, 12, C_Z, 0, 1, 2'b10));
      // ready arrives exactly on the limit cycle
      rst_pulse();
      for (int i = 0; i < 15; i++) cyc(mk("lim_fetch", OP_R, 0, 1, 0, C_F0, 0, 0, 2'b00));
      cyc(mk("lim_ready", OP_R, 1, 1, 0, C_F1, 0, 0, 2'b00));
      cyc(mk("lim_dec", OP_R, 1, 1, 1, C_DEC, 0, 0, 2'b00));
      // wait count restarts per state: MEMREAD times out after its own 16 cycles
      rst_pulse();
      for (int i = 0; i < 10; i++) cyc(mk("mrt_fetch", OP_LW, 0, 1, 0, C_F0, 0, 0, 2'b00));
      cyc(mk("mrt_f1", OP_LW, 1, 1, 0, C_F1, 0, 0, 2'b00));
      cyc(mk("mrt_d", OP_LW, 1, 1, 1, C_DEC, 0, 0, 2'b00));
      cyc(mk("mrt_ma", OP_LW, 1, 1, 2, C_MA, 0, 0, 2'b00));
      for (int i = 0; i < 16; i++) cyc(mk("mrt_wait", OP_LW, 0, 1, 3, C_MR, 0, 0, 2'b00));
      cyc(mk("mrt_err", OP_LW, 0, 1, 12, C_Z, 0, 1, 2'b10));
      // MEMWRITE completes on the limit cycle
      rst_pulse();
      cyc(mk("mwl_f", OP_SW, 1, 1, 0, C_F1, 0, 0, 2'b00));
      cyc(mk("mwl_d", OP_SW, 1, 1, 1, C_DEC, 0, 0, 2'b00));
      cyc(mk("mwl_ma", OP_SW, 1, 1, 2, C_MA, 0, 0, 2'b00));
      for (int i = 0; i < 15; i++) cyc(mk("mwl_wait", OP_SW, 0, 1, 5, C_MW, 0, 0, 2'b00));
      cyc(mk("mwl_done", OP_SW, 1, 1, 5, C_MW, 1, 0, 2'b00));
      cyc(mk("mwl_fetch", OP_SW, 0, 1, 0, C_F0, 0, 0, 2'b00));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
